wave_meter: RTL and testbench
=============================

# wave_meter

Memory-mapped input-waveform meter for the Nios II system. It measures the period and high time of an external square wave in clock cycles, which is the receive-side counterpart of the system's `out_wave` tone generator. The block is attached as an Avalon-MM slave next to the existing PIO peripherals, and firmware polls it to read back frequency and duty cycle. It lets firmware close the loop on the generated tone, or characterise any external digital signal.

## Interface
- `CNT_W`, 32: width of the period/high counters and result registers.
- `TIMEOUT`, 50_000_000: cycles without a completed period before the measurement is abandoned (1 s at 50 MHz).
- `clk_clk`  in  1  system clock, single clock domain.
- `reset_reset`  in  1  synchronous, active-high reset.
- `in_wave_in_wave`  in  1  asynchronous external square wave.
- `avs_address`  in  2  word address: 0 CTRL, 1 STATUS, 2 PERIOD, 3 HIGH.
- `avs_read`  in  1  read strobe.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `avs_readdata`  out  32  read data, registered.

## Operation
- Input path:
  - 2-flop synchronizer, then an edge-detect register.
  - Produces one-cycle `rise`/`fall` pulses.
- CTRL (R/W):
  - bit0 `enable`.
  - bit1 `clear` is write-only and self-clearing; it zeroes STATUS, PERIOD and HIGH, and forces the FSM to ARM.
- STATUS (RO):
  - bit0 `valid`: new result available.
  - bit1 `timeout`: sticky.
  - bit2 `overrun`: sticky; a result was overwritten while `valid` was still set.
- FSM states and transitions:
  - IDLE: entered when `enable`=0, from any state. Counters hold at 0.
  - ARM: wait for `rise`, then go to HIGH_PH with `per_cnt`=1 and `hi_cnt`=1.
  - HIGH_PH: both counters increment each cycle; on `fall` go to LOW_PH.
  - LOW_PH: `per_cnt` increments. On `rise`, latch PERIOD←`per_cnt` and HIGH←`hi_cnt`, set `valid`, set `overrun` if `valid` was already 1, restart both counters at 1, and go to HIGH_PH.
- Timeout: if `per_cnt` reaches `TIMEOUT` in HIGH_PH or LOW_PH, set `timeout` and go to ARM. Result registers are unchanged.
- Counters saturate at 2^CNT_W−1; they never wrap.
- Reading HIGH (address 3) clears `valid`. Firmware reads PERIOD first, then HIGH.
- Writes to STATUS, PERIOD and HIGH are ignored.

## Timing
- Reset values: all registers 0, `avs_readdata`=0, FSM in IDLE.
- Read latency is 1 cycle: `avs_readdata` is valid the cycle after `avs_read`, and holds its value otherwise.
- Pin-to-detection latency is 3 cycles for both edges, so PERIOD and HIGH carry no offset error.
- Minimum measurable high or low phase is 1 cycle of the synchronized signal.
- Simultaneous events:
  - Read of HIGH in the same cycle as a result latch: the new result wins, `valid` stays 1, `overrun` is not set.
  - `clear` in the same cycle as a latch or timeout: `clear` wins and all values end at 0.
  - `enable` deasserted mid-period: the partial measurement is discarded and results are kept.
  - `reset_reset` mid-measurement: returns to the reset state next cycle.

## Structure
- Package `wave_meter_pkg`:
  - FSM state enum (IDLE, ARM, HIGH_PH, LOW_PH).
  - Register address constants.
  - STATUS and CTRL bit indices.
- Sub-module `sync_edge`: 2-flop synchronizer plus `rise`/`fall` detect, reusable for the keys/switches inputs.
- Top level holds the FSM, counters, result registers and Avalon read mux.

## Test plan
- Wave with 100-cycle period and 40 cycles high, enable=1 → after the second rising edge PERIOD=100, HIGH=40, STATUS=0x1. Reading address 3 gives STATUS=0x0.
- Two periods complete without reading HIGH → STATUS=0x5 and PERIOD/HIGH hold the latest values.
- Input held low for more than TIMEOUT=1000 (bench override) → STATUS.timeout=1, FSM in ARM, old results unchanged.
- Write CTRL=0x3 in the same cycle as a result latch → PERIOD=HIGH=STATUS=0 and the FSM is in ARM.
- Disable mid-HIGH_PH, then re-enable → first new result is only reported after a full fresh period; no partial counts.
- Assert reset_reset during LOW_PH → next cycle all registers and readdata are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/wave_meter_pkg.sv
// Shared definitions for the wave_meter square-wave period/duty meter.
package wave_meter_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HIGH_PH = 2'd2,
    LOW_PH  = 2'd3
  } state_t;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_HIGH   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;

  // STATUS bit positions
  localparam int STAT_VALID   = 0;
  localparam int STAT_TIMEOUT = 1;
  localparam int STAT_OVERRUN = 2;

endpackage

// File: rtl/wave_meter_sync_edge.sv
// Two-flop synchronizer followed by an edge-detect register.
// rise/fall are one-cycle pulses derived from the synchronized level.
module sync_edge (
  input  logic clk,
  input  logic srst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/wave_meter.sv
// Avalon-MM slave that measures period and high time of an external
// square wave in clock cycles. Firmware reads PERIOD then HIGH.
module wave_meter
  import wave_meter_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        in_wave_in_wave,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // Saturating increment: counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             rise;
  logic             fall;
  state_t           state_reg;
  logic [CNT_W-1:0] per_cnt_reg;
  logic [CNT_W-1:0] hi_cnt_reg;
  logic [CNT_W-1:0] period_reg;
  logic [CNT_W-1:0] high_reg;
  logic             valid_reg;
  logic             timeout_reg;
  logic             overrun_reg;
  logic             enable_reg;
  logic [31:0]      status_word;

  logic wr_ctrl;
  logic clear;
  logic rd_high;
  logic unused_wdata;

  assign wr_ctrl      = avs_write && (avs_address == ADDR_CTRL);
  assign clear        = wr_ctrl && avs_writedata[CTRL_CLEAR];
  assign rd_high      = avs_read && (avs_address == ADDR_HIGH);
  assign unused_wdata = ^avs_writedata[31:2];

  sync_edge u_sync (
    .clk  (clk_clk),
    .srst (reset_reset),
    .din  (in_wave_in_wave),
    .rise (rise),
    .fall (fall)
  );

  // Measurement FSM, counters, result registers and status flags
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg   <= IDLE;
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (clear) begin
      // clear beats any latch or timeout happening in the same cycle
      state_reg   <= ARM;
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
      period_reg  <= '0;
      high_reg    <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      overrun_reg <= 1'b0;
    end else if (!enable_reg) begin
      // partial measurement is dropped, results are kept
      state_reg   <= IDLE;
      per_cnt_reg <= '0;
      hi_cnt_reg  <= '0;
      if (rd_high) valid_reg <= 1'b0;
    end else begin
      // a latch later in this branch overrides the read-clear of valid
      if (rd_high) valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          state_reg   <= ARM;
          per_cnt_reg <= '0;
          hi_cnt_reg  <= '0;
        end
        ARM: begin
          per_cnt_reg <= '0;
          hi_cnt_reg  <= '0;
          if (rise) begin
            state_reg   <= HIGH_PH;
            per_cnt_reg <= CNT_ONE;
            hi_cnt_reg  <= CNT_ONE;
          end
        end
        HIGH_PH: begin
          if (per_cnt_reg == TIMEOUT_C) begin
            timeout_reg <= 1'b1;
            state_reg   <= ARM;
            per_cnt_reg <= '0;
            hi_cnt_reg  <= '0;
          end else begin
            per_cnt_reg <= sat_inc(per_cnt_reg);
            if (fall) state_reg  <= LOW_PH;
            else      hi_cnt_reg <= sat_inc(hi_cnt_reg);
          end
        end
        LOW_PH: begin
          if (per_cnt_reg == TIMEOUT_C) begin
            timeout_reg <= 1'b1;
            state_reg   <= ARM;
            per_cnt_reg <= '0;
            hi_cnt_reg  <= '0;
          end else if (rise) begin
            period_reg  <= per_cnt_reg;
            high_reg    <= hi_cnt_reg;
            valid_reg   <= 1'b1;
            // a HIGH read in this same cycle consumed the old result
            if (valid_reg && !rd_high) overrun_reg <= 1'b1;
            per_cnt_reg <= CNT_ONE;
            hi_cnt_reg  <= CNT_ONE;
            state_reg   <= HIGH_PH;
          end else begin
            per_cnt_reg <= sat_inc(per_cnt_reg);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // STATUS word assembly
  always_comb begin
    status_word               = '0;
    status_word[STAT_VALID]   = valid_reg;
    status_word[STAT_TIMEOUT] = timeout_reg;
    status_word[STAT_OVERRUN] = overrun_reg;
  end

  // CTRL register and registered Avalon read mux
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      enable_reg   <= 1'b0;
      avs_readdata <= '0;
    end else begin
      if (wr_ctrl) enable_reg <= avs_writedata[CTRL_ENABLE];
      if (avs_read) begin
        case (avs_address)
          ADDR_CTRL:   avs_readdata <= {31'b0, enable_reg};
          ADDR_STATUS: avs_readdata <= status_word;
          ADDR_PERIOD: avs_readdata <= 32'(period_reg);
          default:     avs_readdata <= 32'(high_reg);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Randomized scoreboard bench for wave_meter. The reference model works
// on whole waveform periods: each pin rise reports the previous period.
`timescale 1ns/1ps
module tb_wave_meter;
  import wave_meter_pkg::*;

  localparam int TOUT = 1000;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        in_wave;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  always #5 clk_clk = ~clk_clk;

  wave_meter #(.CNT_W(32), .TIMEOUT(TOUT)) dut (
    .clk_clk         (clk_clk),
    .reset_reset     (reset_reset),
    .in_wave_in_wave (in_wave),
    .avs_address     (avs_address),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_val_q[$];
  string       exp_name_q[$];
  logic        rd_flag = 1'b0;
  logic [31:0] last_val = '0;

  // reference model state
  logic        m_en, m_meas, m_valid, m_tout, m_ovr;
  logic [31:0] m_per, m_hi;
  int          prev_hi, prev_per;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // a read strobe seen at a posedge presents data after that edge
  always @(posedge clk_clk) rd_flag <= avs_read && !reset_reset;

  // monitor: pop the scoreboard whenever read data is presented
  initial begin
    forever begin
      @(negedge clk_clk);
      if (rd_flag) begin
        if (exp_val_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got 0x%08h, expected none", avs_readdata);
        end else begin
          last_val = exp_val_q.pop_front();
          check(exp_name_q.pop_front(), avs_readdata, last_val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] status_exp();
    return {29'b0, m_ovr, m_tout, m_valid};
  endfunction

  function automatic void model_reset();
    m_en = 0; m_meas = 0; m_valid = 0; m_tout = 0; m_ovr = 0;
    m_per = 0; m_hi = 0;
  endfunction

  // a rising pin edge completes the previous period if one was in progress
  function automatic void model_rise();
    if (m_en) begin
      if (m_meas) begin
        if (m_valid) m_ovr = 1;
        m_valid = 1;
        m_per   = prev_per;
        m_hi    = prev_hi;
      end
      m_meas = 1;
    end
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1;
    tick(1);
    avs_write = 0;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] e, string nm);
    exp_val_q.push_back(e);
    exp_name_q.push_back(nm);
    avs_address = a; avs_read = 1;
    tick(1);
    avs_read = 0;
  endtask

  task automatic rd_model(logic [1:0] a, string nm);
    case (a)
      ADDR_CTRL:   rd(a, {31'b0, m_en}, nm);
      ADDR_STATUS: rd(a, status_exp(), nm);
      ADDR_PERIOD: rd(a, m_per, nm);
      default: begin
        rd(a, m_hi, nm);
        m_valid = 0;
      end
    endcase
  endtask

  // one full waveform period; optional register reads mid low phase (lo >= 16)
  task automatic period(int hi, int lo, bit reads, string tag);
    model_rise();
    in_wave = 1;
    tick(hi);
    in_wave = 0;
    if (reads) begin
      tick(6);
      rd_model(ADDR_STATUS, {tag, "_status"});
      rd_model(ADDR_PERIOD, {tag, "_period"});
      rd_model(ADDR_HIGH,   {tag, "_high"});
      rd_model(ADDR_STATUS, {tag, "_status_after"});
      tick(lo - 10);
    end else begin
      tick(lo);
    end
    prev_hi  = hi;
    prev_per = hi + lo;
  endtask

  initial begin
    int hi, lo;
    bit r;
    in_wave = 0; avs_address = 0; avs_read = 0; avs_write = 0; avs_writedata = 0;
    reset_reset = 1;
    model_reset();
    prev_hi = 0; prev_per = 0;
    tick(4);
    check("reset_readdata", avs_readdata, 32'h0);
    reset_reset = 0;
    tick(1);
    rd_model(ADDR_CTRL,   "rst_ctrl");
    rd_model(ADDR_STATUS, "rst_status");
    rd_model(ADDR_PERIOD, "rst_period");
    rd_model(ADDR_HIGH,   "rst_high");

    wr(ADDR_CTRL, 32'h1); m_en = 1; m_meas = 0;
    rd_model(ADDR_CTRL, "ctrl_enabled");
    tick(5);

    // 100-cycle period, 40 high
    period(40, 60, 0, "p0");
    period(40, 60, 1, "p100");

    // two results without reading HIGH -> overrun
    period(40, 60, 0, "o0");
    period(30, 50, 0, "o1");
    period(20, 20, 1, "ovr");

    // randomized periods
    for (int i = 0; i < 10; i++) begin
      hi = $urandom_range(1, 50);
      r  = 1'($urandom_range(0, 1));
      lo = r ? $urandom_range(16, 50) : $urandom_range(1, 50);
      period(hi, lo, r, $sformatf("rnd%0d", i));
    end

    // input stuck low past the timeout
    model_rise();
    in_wave = 1; tick(30); in_wave = 0; tick(1500);
    m_tout = 1; m_meas = 0;
    rd_model(ADDR_STATUS, "tout_status");
    rd_model(ADDR_PERIOD, "tout_period");
    rd_model(ADDR_HIGH,   "tout_high");
    period(20, 30, 0, "tarm");
    period(20, 30, 1, "tmeas");

    // clear written in the same cycle as a result latch
    in_wave = 1; tick(2);
    wr(ADDR_CTRL, 32'h3);
    m_per = 0; m_hi = 0; m_valid = 0; m_tout = 0; m_ovr = 0; m_meas = 0; m_en = 1;
    tick(17); in_wave = 0; tick(6);
    rd_model(ADDR_STATUS, "clr_status");
    rd_model(ADDR_PERIOD, "clr_period");
    rd_model(ADDR_HIGH,   "clr_high");
    rd_model(ADDR_CTRL,   "clr_ctrl");
    tick(20);
    period(15, 25, 0, "carm");
    period(15, 25, 1, "cmeas");

    // HIGH read in the same cycle as a result latch
    period(12, 30, 0, "rh0");
    in_wave = 1; tick(2);
    rd(ADDR_HIGH, m_hi, "hi_race_old");
    m_valid = 0;
    model_rise();
    tick(9); in_wave = 0; tick(6);
    rd_model(ADDR_STATUS, "hi_race_status");
    rd_model(ADDR_PERIOD, "hi_race_period");
    rd_model(ADDR_HIGH,   "hi_race_high");
    tick(20);
    prev_hi = 12; prev_per = 41;

    // disable mid high phase, then re-enable
    model_rise();
    in_wave = 1; tick(8);
    wr(ADDR_CTRL, 32'h0); m_en = 0; m_meas = 0;
    rd_model(ADDR_CTRL, "dis_ctrl");
    wr(ADDR_CTRL, 32'h1); m_en = 1;
    tick(10); in_wave = 0; tick(30);
    rd_model(ADDR_PERIOD, "dis_period_kept");
    tick(5);
    period(20, 30, 1, "darm");
    period(25, 30, 1, "dmeas");

    // reset during the low phase
    model_rise();
    in_wave = 1; tick(20); in_wave = 0; tick(8);
    rd_model(ADDR_PERIOD, "pre_rst_period");
    tick(3);
    check("readdata_hold", avs_readdata, last_val);
    reset_reset = 1; tick(1); reset_reset = 0;
    model_reset();
    check("rst_mid_readdata", avs_readdata, 32'h0);
    rd_model(ADDR_CTRL,   "rst2_ctrl");
    rd_model(ADDR_STATUS, "rst2_status");
    rd_model(ADDR_PERIOD, "rst2_period");
    rd_model(ADDR_HIGH,   "rst2_high");
    tick(3);
    check("scoreboard_drained", 32'(exp_val_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
